// File: rtl/min_security_scheduler.sv
// Crypto engine job scheduler: auth-gated dispatch, a watchdog per engine and
// round-robin reporting of completed or timed-out jobs.
module min_security_scheduler #(
  parameter int unsigned  NUM_ENG   = 4,
  parameter int unsigned  TIMEOUT_W = 16,
  parameter int unsigned  ID_W      = 32,
  localparam int unsigned EW        = $clog2(NUM_ENG)
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 auth_ok,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [EW-1:0]        req_eng,
  input  logic [ID_W-1:0]      req_id,
  output logic [NUM_ENG-1:0]   eng_start,
  output logic [NUM_ENG-1:0]   eng_abort,
  output logic [ID_W-1:0]      eng_id,
  input  logic [NUM_ENG-1:0]   eng_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [EW-1:0]        rsp_eng,
  output logic [1:0]           rsp_status,
  output logic [NUM_ENG-1:0]   busy,
  output logic [7:0]           err_cnt
);

  localparam int unsigned ErrW = $clog2(NUM_ENG + 2);

  typedef enum logic [1:0] {StIdle, StRun, StPend} eng_state_e;

  eng_state_e             state_q [NUM_ENG];
  eng_state_e             state_d [NUM_ENG];
  logic [TIMEOUT_W-1:0]   wdog_q  [NUM_ENG];
  logic [TIMEOUT_W-1:0]   wdog_d  [NUM_ENG];
  logic [NUM_ENG-1:0]     tmo_q, tmo_d;
  logic [NUM_ENG-1:0]     start_q, start_d;
  logic [NUM_ENG-1:0]     abort_q, abort_d;
  logic [ID_W-1:0]        eng_id_q, eng_id_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [EW-1:0]          rsp_eng_q, rsp_eng_d;
  logic [1:0]             rsp_status_q, rsp_status_d;
  logic [EW-1:0]          rr_q, rr_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic                   req_in_range;
  logic                   req_eng_idle;
  logic                   pend_found;
  logic [EW-1:0]          pend_idx;
  int unsigned            scan_idx;
  logic [ErrW-1:0]        err_events;
  logic [8:0]             err_sum;

  // Indices at or above NUM_ENG never match, so they are always accepted and then dropped.
  always_comb begin
    req_in_range = 1'b0;
    req_eng_idle = 1'b0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (req_eng == EW'(i)) begin
        req_in_range = 1'b1;
        req_eng_idle = (state_q[i] == StIdle);
      end
    end
  end

  assign req_ready = auth_ok && (!req_in_range || req_eng_idle);

  // First PEND engine at or after rr, wrapping.
  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    scan_idx   = 0;
    for (int unsigned k = 0; k < NUM_ENG; k++) begin
      scan_idx = 32'(rr_q) + k;
      if (scan_idx >= NUM_ENG) begin
        scan_idx = scan_idx - NUM_ENG;
      end
      if (!pend_found && state_q[scan_idx[EW-1:0]] == StPend) begin
        pend_found = 1'b1;
        pend_idx   = scan_idx[EW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    tmo_d        = tmo_q;
    start_d      = '0;
    abort_d      = '0;
    eng_id_d     = eng_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_eng_d    = rsp_eng_q;
    rsp_status_d = rsp_status_q;
    rr_d         = rr_q;
    err_events   = '0;

    if (req_valid && req_ready) begin
      if (req_in_range) begin
        for (int i = 0; i < NUM_ENG; i++) begin
          if (req_eng == EW'(i)) begin
            state_d[i] = StRun;
            wdog_d[i]  = '0;
            start_d[i] = 1'b1;
          end
        end
        eng_id_d = req_id;
      end else begin
        err_events = err_events + 1'b1;
      end
    end

    // Done beats a watchdog expiry landing in the same cycle.
    for (int i = 0; i < NUM_ENG; i++) begin
      if (state_q[i] == StRun) begin
        if (eng_done[i]) begin
          state_d[i] = StPend;
          tmo_d[i]   = 1'b0;
        end else if (timeout_lim != '0 && wdog_q[i] == timeout_lim) begin
          state_d[i] = StPend;
          tmo_d[i]   = 1'b1;
          abort_d[i] = 1'b1;
          err_events = err_events + 1'b1;
        end else if (wdog_q[i] != '1) begin
          wdog_d[i] = wdog_q[i] + 1'b1;
        end
      end
    end

    if (rsp_valid_q) begin
      if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
          if (rsp_eng_q == EW'(i)) begin
            state_d[i] = StIdle;
          end
        end
        rr_d = (rsp_eng_q == EW'(NUM_ENG - 1)) ? '0 : rsp_eng_q + 1'b1;
      end
    end else if (pend_found) begin
      rsp_valid_d  = 1'b1;
      rsp_eng_d    = pend_idx;
      rsp_status_d = {1'b0, tmo_q[pend_idx]};
    end

    err_sum   = {1'b0, err_cnt_q} + 9'(err_events);
    err_cnt_d = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_ENG; i++) begin
        state_q[i] <= StIdle;
        wdog_q[i]  <= '0;
      end
      tmo_q        <= '0;
      start_q      <= '0;
      abort_q      <= '0;
      eng_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_eng_q    <= '0;
      rsp_status_q <= '0;
      rr_q         <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      tmo_q        <= tmo_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      eng_id_q     <= eng_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_eng_q    <= rsp_eng_d;
      rsp_status_q <= rsp_status_d;
      rr_q         <= rr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      busy[i] = (state_q[i] != StIdle);
    end
  end

  assign eng_start  = start_q;
  assign eng_abort  = abort_q;
  assign eng_id     = eng_id_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_eng    = rsp_eng_q;
  assign rsp_status = rsp_status_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_min_security_scheduler.sv
// Bench for min_security_scheduler: cycle model with per-cycle compare on a
// 4-engine build, plus directed checks on a 3-engine build for out-of-range IDs.
module tb_min_security_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        auth_ok;
  logic [15:0] timeout_lim;
  logic        req_valid, req_ready;
  logic [1:0]  req_eng;
  logic [31:0] req_id;
  logic [3:0]  eng_start, eng_abort, eng_done, busy;
  logic [31:0] eng_id;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_eng, rsp_status;
  logic [7:0]  err_cnt;

  logic        d3_req_valid, d3_req_ready;
  logic [1:0]  d3_req_eng;
  logic [2:0]  d3_eng_start, d3_eng_abort, d3_busy;
  logic [31:0] d3_eng_id;
  logic        d3_rsp_valid;
  logic [1:0]  d3_rsp_eng, d3_rsp_status;
  logic [7:0]  d3_err_cnt;

  always #5 clk = ~clk;

  min_security_scheduler #(.NUM_ENG(4), .TIMEOUT_W(16), .ID_W(32)) dut (
    .clk(clk), .nreset(nreset), .auth_ok(auth_ok), .timeout_lim(timeout_lim),
    .req_valid(req_valid), .req_ready(req_ready), .req_eng(req_eng), .req_id(req_id),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_id(eng_id), .eng_done(eng_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_eng(rsp_eng),
    .rsp_status(rsp_status), .busy(busy), .err_cnt(err_cnt)
  );

  min_security_scheduler #(.NUM_ENG(3), .TIMEOUT_W(16), .ID_W(32)) dut3 (
    .clk(clk), .nreset(nreset), .auth_ok(1'b1), .timeout_lim(16'd0),
    .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_eng(d3_req_eng),
    .req_id(32'h3333_0000), .eng_start(d3_eng_start), .eng_abort(d3_eng_abort),
    .eng_id(d3_eng_id), .eng_done(3'b000), .rsp_valid(d3_rsp_valid), .rsp_ready(1'b1),
    .rsp_eng(d3_rsp_eng), .rsp_status(d3_rsp_status), .busy(d3_busy), .err_cnt(d3_err_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: engine phase 0=idle 1=run 2=pend, age = cycles spent in run so far.
  int          m_st  [N];
  int          m_age [N];
  bit          m_tmo [N];
  logic [3:0]  m_start, m_abort;
  logic [31:0] m_id;
  bit          m_rv;
  int          m_re, m_rs, m_rr, m_err;

  function automatic bit m_ready();
    return auth_ok && (int'(req_eng) >= N || m_st[req_eng] == 0);
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] b;
    for (int i = 0; i < N; i++) b[i] = (m_st[i] != 0);
    return b;
  endfunction

  always @(posedge clk or negedge nreset) begin : model
    int nst [N];
    int errs;
    int j;
    if (!nreset) begin
      for (int i = 0; i < N; i++) begin
        m_st[i] = 0; m_age[i] = 0; m_tmo[i] = 0;
      end
      m_start = '0; m_abort = '0; m_id = '0;
      m_rv = 0; m_re = 0; m_rs = 0; m_rr = 0; m_err = 0;
    end else begin
      nst = m_st;
      errs = 0;
      m_start = '0;
      m_abort = '0;
      if (req_valid && m_ready()) begin
        if (int'(req_eng) < N) begin
          nst[req_eng] = 1; m_age[req_eng] = 0; m_start[req_eng] = 1'b1; m_id = req_id;
        end else begin
          errs++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_st[i] == 1) begin
          if (eng_done[i]) begin
            nst[i] = 2; m_tmo[i] = 0;
          end else if (timeout_lim != 0 && m_age[i] == int'(timeout_lim)) begin
            nst[i] = 2; m_tmo[i] = 1; m_abort[i] = 1'b1; errs++;
          end else if (m_age[i] < 65535) begin
            m_age[i]++;
          end
        end
      end
      if (m_rv) begin
        if (rsp_ready) begin
          nst[m_re] = 0; m_rv = 0; m_rr = (m_re + 1) % N;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!m_rv && m_st[j] == 2) begin
            m_rv = 1; m_re = j; m_rs = int'(m_tmo[j]);
          end
        end
      end
      m_err = (m_err + errs > 255) ? 255 : m_err + errs;
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_ready());
    chk("eng_start", eng_start, m_start);
    chk("eng_abort", eng_abort, m_abort);
    if (m_start != 0 || !nreset) chk("eng_id", eng_id, m_id);
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv || !nreset) begin
      chk("rsp_eng", rsp_eng, m_re);
      chk("rsp_status", rsp_status, m_rs);
    end
    chk("busy", busy, m_busy());
    chk("err_cnt", err_cnt, m_err);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [1:0] e, input logic [31:0] id);
    req_valid = 1'b1; req_eng = e; req_id = id;
    step(1);
    req_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [3:0] m);
    eng_done = m;
    step(1);
    eng_done = '0;
  endtask

  int order_q[$];

  function automatic int ord(input int k);
    return (k < order_q.size()) ? order_q[k] : -1;
  endfunction

  task automatic collect(input int n);
    order_q.delete();
    for (int t = 0; t < 40 && order_q.size() < n; t++) begin
      if (rsp_valid && rsp_ready) order_q.push_back(int'(rsp_eng));
      if (order_q.size() < n) step(1);
    end
    chk("collect_count", order_q.size(), n);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    auth_ok = 1'b1; timeout_lim = '0; req_valid = 1'b0; req_eng = '0; req_id = '0;
    eng_done = '0; rsp_ready = 1'b1; d3_req_valid = 1'b0; d3_req_eng = '0;
    #1 nreset = 1'b0;
    step(2);
    chk("rst_start", eng_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err_cnt, 0);
    nreset = 1'b1;
    step(1);

    // Round-robin from rr=0, then from rr=2.
    request(2'd0, 32'h1);
    chk("start_e0", eng_start, 4'b0001);
    request(2'd1, 32'h2);
    request(2'd3, 32'h3);
    chk("busy_013", busy, 4'b1011);
    done_pulse(4'b1011);
    collect(3);
    chk("rr_first", ord(0), 0);
    chk("rr_second", ord(1), 1);
    chk("rr_third", ord(2), 3);
    request(2'd1, 32'h4);
    done_pulse(4'b0010);
    collect(1);
    chk("rr_e1_only", ord(0), 1);
    request(2'd0, 32'h5);
    request(2'd3, 32'h6);
    done_pulse(4'b1001);
    collect(2);
    chk("rr2_first", ord(0), 3);
    chk("rr2_second", ord(1), 0);

    // Basic job on engine 2.
    request(2'd2, 32'hA5A5_A5A5);
    chk("basic_start", eng_start, 4'b0100);
    chk("basic_id", eng_id, 32'hA5A5_A5A5);
    chk("basic_busy", busy, 4'b0100);
    step(1);
    chk("basic_start_off", eng_start, 4'b0000);
    step(3);
    done_pulse(4'b0100);
    step(1);
    chk("basic_rsp_valid", rsp_valid, 1);
    chk("basic_rsp_eng", rsp_eng, 2);
    chk("basic_rsp_status", rsp_status, 0);
    chk("basic_busy_held", busy, 4'b0100);
    step(1);
    chk("basic_busy_clear", busy, 4'b0000);

    // Watchdog expiry at limit 8, then done in the expiry cycle.
    timeout_lim = 16'd8;
    request(2'd1, 32'h77);
    n = 0;
    while (eng_abort == 0 && n < 20) begin
      step(1);
      n++;
    end
    chk("tmo_latency", n, 9);
    chk("tmo_abort", eng_abort, 4'b0010);
    chk("tmo_err", err_cnt, 1);
    step(1);
    chk("tmo_abort_off", eng_abort, 4'b0000);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_eng", rsp_eng, 1);
    chk("tmo_rsp_status", rsp_status, 1);
    step(1);
    request(2'd1, 32'h78);
    step(8);
    done_pulse(4'b0010);
    chk("race_no_abort", eng_abort, 4'b0000);
    chk("race_err", err_cnt, 1);
    step(1);
    chk("race_rsp_eng", rsp_eng, 1);
    chk("race_rsp_status", rsp_status, 0);
    step(1);
    timeout_lim = '0;

    // Auth gating and busy-engine rejection.
    auth_ok = 1'b0; req_valid = 1'b1; req_eng = 2'd2; req_id = 32'h123;
    #1;
    chk("noauth_ready", req_ready, 0);
    step(1);
    chk("noauth_start", eng_start, 0);
    chk("noauth_busy", busy, 0);
    req_valid = 1'b0; auth_ok = 1'b1;
    request(2'd2, 32'h1111);
    req_valid = 1'b1; req_eng = 2'd2;
    #1;
    chk("busy_eng_ready", req_ready, 0);
    step(1);
    chk("busy_eng_start", eng_start, 0);
    req_valid = 1'b0;
    auth_ok = 1'b0;
    done_pulse(4'b0100);
    collect(1);
    chk("noauth_rsp_eng", ord(0), 2);
    auth_ok = 1'b1;

    // Out-of-range index on the 3-engine build, then err_cnt saturation.
    d3_req_valid = 1'b1; d3_req_eng = 2'd3;
    #1;
    chk("d3_oor_ready", d3_req_ready, 1);
    step(1);
    d3_req_valid = 1'b0;
    chk("d3_oor_start", d3_eng_start, 3'b000);
    chk("d3_oor_err", d3_err_cnt, 1);
    chk("d3_oor_busy", d3_busy, 3'b000);
    d3_req_valid = 1'b1; d3_req_eng = 2'd2;
    step(1);
    d3_req_valid = 1'b0;
    chk("d3_start_e2", d3_eng_start, 3'b100);
    d3_req_valid = 1'b1; d3_req_eng = 2'd3;
    step(300);
    d3_req_valid = 1'b0;
    chk("d3_err_sat", d3_err_cnt, 255);

    // Back-pressure: response held while a second completion queues.
    rsp_ready = 1'b0;
    request(2'd0, 32'h10);
    request(2'd2, 32'h12);
    done_pulse(4'b0001);
    for (int t = 0; t < 10 && !rsp_valid; t++) step(1);
    chk("hold_valid0", rsp_valid, 1);
    chk("hold_eng0", rsp_eng, 0);
    for (int i = 0; i < 10; i++) begin
      eng_done = (i == 2) ? 4'b0100 : 4'b0000;
      step(1);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_eng", rsp_eng, 0);
      chk("hold_status", rsp_status, 0);
    end
    eng_done = '0;
    rsp_ready = 1'b1;
    collect(2);
    chk("hold_order0", ord(0), 0);
    chk("hold_order1", ord(1), 2);

    // Reset with two engines running.
    request(2'd1, 32'h21);
    request(2'd3, 32'h23);
    chk("pre_rst_start", eng_start, 4'b1000);
    #1 nreset = 1'b0;
    #1;
    chk("mid_rst_start", eng_start, 0);
    chk("mid_rst_abort", eng_abort, 0);
    chk("mid_rst_id", eng_id, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_eng", rsp_eng, 0);
    chk("mid_rst_rsp_status", rsp_status, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("in_rst_abort", eng_abort, 0);
    end
    nreset = 1'b1;
    request(2'd1, 32'hBEEF);
    chk("post_rst_start", eng_start, 4'b0010);
    chk("post_rst_id", eng_id, 32'hBEEF);
    done_pulse(4'b0010);
    collect(1);
    chk("post_rst_rsp", ord(0), 1);
    chk("post_rst_err", err_cnt, 0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
